// File: rtl/rc_sched_pkg.sv
// rc_sched_pkg: FSM encoding, partition sizing and watchdog limit shared by the RC partition scheduler
package rc_sched_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, FEED, WAIT, OUT, DONE} state_t;
    localparam logic [15:0] WD_LIMIT = 16'd4096;
    // A remainder of 4 with row size 3 splits 2+2 so no single-row tail partition is left behind
    function automatic int unsigned part_size(int unsigned rem, int unsigned rsiz);
        if (rsiz == 3 && rem == 4) return 2;
        return rem < rsiz ? rem : rsiz;
    endfunction
endpackage

// File: rtl/rc_column_buffer.sv
// rc_column_buffer: small column store filled in arrival order, read by index
// Ports: clk/reset_n; clr rewinds the write pointer; wr_en/wr_data append a column;
// rd_ptr/rd_data combinational read; count = columns written since the last clear.
module rc_column_buffer #(
    parameter int W     = 1024,
    parameter int DEPTH = 3,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_ptr,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en) begin
            mem[count[PW-1:0]] <= wr_data;
            count <= count + CW'(1);
        end
    end
    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/rc_partition_scheduler.sv
// rc_partition_scheduler: walks step windows and kernel-index partitions of a lowered IFM through the RC
// Ports: start/cfg_* launch a run, busy/done/err report it; mem_* fetch LIFM columns (req held until gnt,
// data returns in order on rvalid); rc_* strobe and feed the RC and take rc_valid; out_* present each
// partition result with a valid/ready handshake; byp_column carries the row of single-row partitions.
// Optional RC_SCHED_WATCHDOG_EN: abort the run with err if rc_valid does not arrive within WD_LIMIT cycles.
module rc_partition_scheduler
    import rc_sched_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int RSIZ_WIDTH     = 2,
    parameter int MAX_LIFM_RSIZ  = 3,
    parameter int STEP_RANGE     = 128,
    parameter int STEP_CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [WORD_WIDTH-1:0]            cfg_k,
    input  logic [RSIZ_WIDTH-1:0]            cfg_rsiz,
    input  logic [STEP_CNT_WIDTH-1:0]        cfg_steps,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             mem_req,
    output logic [WORD_WIDTH-1:0]            mem_kidx,
    output logic [STEP_CNT_WIDTH-1:0]        mem_step,
    input  logic                             mem_gnt,
    input  logic                             mem_rvalid,
    input  logic [WORD_WIDTH*STEP_RANGE-1:0] mem_rdata,
    output logic                             rc_enable,
    output logic [RSIZ_WIDTH-1:0]            rc_rsiz,
    output logic [WORD_WIDTH-1:0]            rc_kidx,
    output logic [WORD_WIDTH*STEP_RANGE-1:0] rc_column,
    input  logic                             rc_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_bypass,
    output logic                             out_last,
    output logic [STEP_CNT_WIDTH-1:0]        out_step,
    output logic [WORD_WIDTH-1:0]            out_kidx_base,
    output logic [WORD_WIDTH*STEP_RANGE-1:0] byp_column
);
    localparam int PW = $clog2(MAX_LIFM_RSIZ);
    localparam int CW = $clog2(MAX_LIFM_RSIZ + 1);
    localparam int CWID = WORD_WIDTH * STEP_RANGE;
    state_t state;
    logic [WORD_WIDTH-1:0] k_q, kidx_base;
    logic [RSIZ_WIDTH-1:0] rsiz_q, psiz, req_cnt, feed_cnt;
    logic [STEP_CNT_WIDTH-1:0] steps_q, step, step_nxt;
    logic [WORD_WIDTH:0] base_nxt;
    logic [CW-1:0] fill;
    logic [PW-1:0] rd_ptr;
    logic [CWID-1:0] rd_data;
    logic base_wrap, run_end, feeding;
`ifdef RC_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt;
`endif
    assign psiz = RSIZ_WIDTH'(part_size(32'(k_q - kidx_base), 32'(rsiz_q)));
    assign base_nxt = {1'b0, kidx_base} + (WORD_WIDTH + 1)'(psiz);
    assign base_wrap = base_nxt == {1'b0, k_q};
    assign step_nxt = step + STEP_CNT_WIDTH'(1);
    assign run_end = base_wrap && step_nxt == steps_q;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign mem_req = state == FETCH && req_cnt != psiz;
    assign mem_kidx = mem_req ? kidx_base + WORD_WIDTH'(req_cnt) : '0;
    assign mem_step = mem_req ? step : '0;
    // First FEED cycle strobes the RC; the next psiz cycles stream slots 0..psiz-1
    assign rc_enable = state == FEED && feed_cnt == '0;
    assign rc_rsiz = rc_enable ? psiz : '0;
    assign feeding = state == FEED && feed_cnt != '0;
    assign rd_ptr = feeding ? PW'(feed_cnt - RSIZ_WIDTH'(1)) : '0;
    assign rc_kidx = feeding ? kidx_base + WORD_WIDTH'(feed_cnt) - WORD_WIDTH'(1) : '0;
    assign rc_column = feeding ? rd_data : '0;
    assign out_valid = state == OUT;
    assign out_bypass = out_valid && psiz == RSIZ_WIDTH'(1);
    assign out_last = out_valid && run_end;
    assign out_step = out_valid ? step : '0;
    assign out_kidx_base = out_valid ? kidx_base : '0;
    assign byp_column = out_bypass ? rd_data : '0;
    rc_column_buffer #(.W(CWID), .DEPTH(MAX_LIFM_RSIZ), .PW(PW), .CW(CW)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != FETCH),
        .wr_en   (state == FETCH && mem_rvalid && fill != CW'(psiz)),
        .wr_data (mem_rdata),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data),
        .count   (fill)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            err <= 1'b0;
            k_q <= '0;
            rsiz_q <= '0;
            steps_q <= '0;
            kidx_base <= '0;
            step <= '0;
            req_cnt <= '0;
            feed_cnt <= '0;
`ifdef RC_SCHED_WATCHDOG_EN
            wd_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    k_q <= cfg_k;
                    rsiz_q <= cfg_rsiz;
                    steps_q <= cfg_steps;
                    err <= cfg_rsiz < RSIZ_WIDTH'(2);
                    kidx_base <= '0;
                    step <= '0;
                    req_cnt <= '0;
                    state <= (cfg_rsiz < RSIZ_WIDTH'(2) || cfg_k == '0 || cfg_steps == '0) ? DONE : FETCH;
                end
                FETCH: begin
                    feed_cnt <= '0;
                    if (mem_req && mem_gnt) req_cnt <= req_cnt + RSIZ_WIDTH'(1);
                    if (fill == CW'(psiz)) state <= psiz == RSIZ_WIDTH'(1) ? OUT : FEED;
                end
                FEED: begin
                    feed_cnt <= feed_cnt + RSIZ_WIDTH'(1);
`ifdef RC_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    if (feed_cnt == psiz) state <= WAIT;
                end
`ifdef RC_SCHED_WATCHDOG_EN
                WAIT: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (rc_valid) state <= OUT;
                    else if (wd_cnt == WD_LIMIT - 16'd1) begin
                        err <= 1'b1;
                        state <= DONE;
                    end
                end
`else
                WAIT: if (rc_valid) state <= OUT;
`endif
                OUT: if (out_ready) begin
                    req_cnt <= '0;
                    kidx_base <= base_wrap ? '0 : base_nxt[WORD_WIDTH-1:0];
                    step <= base_wrap ? step_nxt : step;
                    state <= run_end ? DONE : FETCH;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
